mac_seq_ctrl: RTL
=================

// Module: mac_seq_ctrl
// PURPOSE
//   Upstream sequencer for mac_wrapper. Buffers (activation, weight) pairs from a valid/ready stream in a small FIFO.
//   Issues pairs one at a time on mac_a/mac_b and feeds the running psum back on mac_c. After len pairs it presents
//   the final psum on a valid/ready output. Owns the accumulation loop, so no external agent supplies c.
// PARAMETERS
//   bw          4   activation/weight width (activation unsigned, weight two's-complement)
//   psum_bw     16  partial-sum width
//   len_bw      5   width of vector-length field (max len = 2^len_bw-1)
//   fifo_depth  4   operand FIFO entries (power of 2, >=2)
//   mac_lat     1   cycles from mac_a/b/c stable to mac_out valid (>=1)
// PORTS
//   clk        in   1        clock, all logic on rising edge
//   reset_n    in   1        synchronous active-low reset
//   start      in   1        begin a dot product; sampled only in IDLE
//   len        in   len_bw   number of pairs; latched with start
//   busy       out  1        high in every state except IDLE
//   in_valid   in   1        operand pair valid
//   in_ready   out  1        FIFO not full
//   in_a       in   bw       activation (unsigned)
//   in_b       in   bw       weight (signed)
//   mac_a      out  bw       to mac_wrapper.a (registered)
//   mac_b      out  bw       to mac_wrapper.b (registered)
//   mac_c      out  psum_bw  to mac_wrapper.c (registered, = current psum)
//   mac_out    in   psum_bw  from mac_wrapper.out
//   out_valid  out  1        final psum valid
//   out_ready  in   1        consumer accepts psum
//   out_psum   out  psum_bw  final psum
// BEHAVIOUR
//   Reset (reset_n=0 at a clk edge): state=IDLE, FIFO emptied, psum=0, remaining=0, wait counter=0.
//     Outputs: mac_a/b/c=0, out_valid=0, out_psum=0, busy=0, in_ready=1.
//     Reset mid-operation aborts the operation. No partial result is emitted.
//   FIFO:
//     - in_ready = !full. Push on in_valid & in_ready, in any state (prefill is allowed).
//     - No bypass: a pair pushed in cycle T is poppable from T+1.
//     - Push and pop in the same cycle are both honoured. Count is unchanged.
//     - Pointers wrap modulo fifo_depth.
//   FSM:
//     IDLE   start=1 -> latch remaining=len, psum=0.
//            If len==0 -> DONE, else -> ISSUE. start=0 -> stay.
//     ISSUE  FIFO non-empty -> pop head. mac_a<=in_a(head), mac_b<=in_b(head), mac_c<=psum.
//            Load wait counter=mac_lat, -> WAIT. FIFO empty -> stay; mac_* hold.
//     WAIT   mac_* hold. Decrement counter each cycle.
//            On the cycle the counter reaches 1, capture psum<=mac_out at that edge and decrement remaining.
//            Then -> DONE if remaining==0, else -> ISSUE.
//     DONE   out_valid=1, out_psum=psum, both held stable until out_ready=1.
//            On out_valid & out_ready -> IDLE, out_valid=0 next cycle.
//   Throughput: 1+mac_lat cycles per pair when the FIFO never runs empty.
//   start outside IDLE is ignored. len is not re-sampled.
//   mac_out is opaque: no saturation or sign handling here. Wrap is modulo 2^psum_bw, done by the MAC.
//   start in the same cycle as a DONE handshake is ignored; it is honoured from IDLE on the next cycle.
// TESTING (bench instantiates mac_wrapper bw=4 psum_bw=16, mac_lat matched)
//   1 Basic: len=3, pairs (3,+2),(15,-8=4'b1000),(1,+7)
//     -> out_valid once, out_psum=16'hFF95 (-107). mac_c sequence 0, 6, 16'hFF8E.
//   2 Zero length: start with len=0
//     -> out_valid=1 the cycle after start, out_psum=0. No FIFO pop, mac_* stay 0.
//   3 Backpressure: out_ready=0 for 5 cycles in DONE
//     -> out_valid and out_psum stable, busy=1. IDLE one cycle after out_ready=1.
//   4 FIFO full/starve: push 4 pairs with no start -> in_ready=0.
//     start len=6 -> in_ready=1 the cycle after the first pop.
//     Starve the last pair 10 cycles -> FSM holds in ISSUE, result still correct.
//   5 Reset mid-op: reset_n=0 for 1 cycle during WAIT of pair 2 of 4
//     -> next cycle all outputs 0, busy=0, in_ready=1. A new start len=1 (5,+1) -> out_psum=5.
//   6 Ignored start: pulse start with len=9 while busy on len=2 -> result covers exactly 2 pairs.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - operand FIFO and accumulation sequencer feeding an external MAC
module mac_seq_ctrl #(
  parameter int bw         = 4,
  parameter int psum_bw    = 16,
  parameter int len_bw     = 5,
  parameter int fifo_depth = 4,
  parameter int mac_lat    = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [len_bw-1:0]  len,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [bw-1:0]      in_a,
  input  logic [bw-1:0]      in_b,
  output logic [bw-1:0]      mac_a,
  output logic [bw-1:0]      mac_b,
  output logic [psum_bw-1:0] mac_c,
  input  logic [psum_bw-1:0] mac_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [psum_bw-1:0] out_psum
);

  localparam int ptr_bw = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int cnt_bw = ptr_bw + 1;
  localparam int lat_bw = $clog2(mac_lat + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state;
  logic [psum_bw-1:0]  psum;
  logic [len_bw-1:0]   remaining;
  logic [lat_bw-1:0]   wait_cnt;

  logic [bw-1:0]       fifo_a [fifo_depth];
  logic [bw-1:0]       fifo_b [fifo_depth];
  logic [ptr_bw-1:0]   wr_ptr;
  logic [ptr_bw-1:0]   rd_ptr;
  logic [cnt_bw-1:0]   count;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;

  assign full     = (count == cnt_bw'(fifo_depth));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = (state == S_ISSUE) && !empty;
  assign busy     = (state != S_IDLE);

  // Storage has no reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= in_a;
      fifo_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_bw'(wr_ptr + 1'b1);
      if (pop)  rd_ptr <= ptr_bw'(rd_ptr + 1'b1);
      if (push && !pop)      count <= cnt_bw'(count + 1'b1);
      else if (pop && !push) count <= cnt_bw'(count - 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      psum      <= '0;
      remaining <= '0;
      wait_cnt  <= '0;
      mac_a     <= '0;
      mac_b     <= '0;
      mac_c     <= '0;
      out_valid <= 1'b0;
      out_psum  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            remaining <= len;
            psum      <= '0;
            if (len == '0) begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              out_psum  <= '0;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (!empty) begin
            mac_a    <= fifo_a[rd_ptr];
            mac_b    <= fifo_b[rd_ptr];
            mac_c    <= psum;
            wait_cnt <= lat_bw'(mac_lat);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= lat_bw'(wait_cnt - 1'b1);
          // mac_out is sampled on the last latency cycle; the last pair goes straight to DONE.
          if (wait_cnt == lat_bw'(1)) begin
            psum      <= mac_out;
            remaining <= len_bw'(remaining - 1'b1);
            if (remaining == len_bw'(1)) begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              out_psum  <= mac_out;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
